// File: rtl/mprj_io_seq_checker.sv
// Watches a WIDTH-bit slice of the user IOs and waits for a programmed ordered sequence of masked values.
// It reports pass, a strict-mode mismatch, or a run-time timeout.
module mprj_io_seq_checker #(
  parameter int WIDTH          = 8,
  parameter int DEPTH          = 16,
  parameter int STABLE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 25000,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             resetb,
  input  logic [WIDTH-1:0] io_in,
  input  logic             exp_we,
  input  logic [AW-1:0]    exp_addr,
  input  logic [WIDTH-1:0] exp_data,
  input  logic [WIDTH-1:0] exp_mask,
  input  logic [LW-1:0]    seq_len,
  input  logic             strict,
  input  logic             start,
  output logic             busy,
  output logic             pass,
  output logic             fail,
  output logic             timed_out,
  output logic [LW-1:0]    match_idx,
  output logic [WIDTH-1:0] fail_value
);

  localparam int SW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [SW-1:0] S_LAST = SW'(STABLE_CYCLES - 1);
  localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam bit            TO_EN  = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PASS, ST_FAIL} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] s1, s2, prev;
  logic [SW-1:0]    stab_cnt;
  logic             evaluated;
  logic             eval_now;

  logic [WIDTH-1:0] data_mem [DEPTH];
  logic [WIDTH-1:0] mask_mem [DEPTH];
  logic             mem_we;
  logic [WIDTH-1:0] cur_data, cur_mask;
  logic             entry_hit, same_as_last;

  logic [LW-1:0]    idx_q, idx_d;
  logic [LW-1:0]    len_q, len_d, len_clamped;
  logic [TW-1:0]    timer_q, timer_d;
  logic             strict_q, strict_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic             pass_d, fail_d, timed_out_d;
  logic [WIDTH-1:0] fail_value_d;

  // A value is evaluated once, when it has sat unchanged at s2 long enough; the
  // evaluated flag stops a held value from being looked at again.
  assign eval_now = (s2 == prev) && (stab_cnt == S_LAST) && !evaluated;

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      s1        <= '0;
      s2        <= '0;
      prev      <= '0;
      stab_cnt  <= '0;
      evaluated <= 1'b0;
    end else begin
      s1   <= io_in;
      s2   <= s1;
      prev <= s2;
      if (s2 != prev) begin
        stab_cnt  <= '0;
        evaluated <= 1'b0;
      end else begin
        if (stab_cnt != S_LAST) stab_cnt <= stab_cnt + SW'(1);
        if (eval_now) evaluated <= 1'b1;
      end
    end
  end

  assign mem_we = exp_we && (state_q != ST_RUN) && ({1'b0, exp_addr} < (AW + 1)'(DEPTH));

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_mem[i] <= '0;
        mask_mem[i] <= '0;
      end
    end else if (mem_we) begin
      data_mem[exp_addr] <= exp_data;
      mask_mem[exp_addr] <= exp_mask;
    end
  end

  assign cur_data     = data_mem[idx_q[AW-1:0]];
  assign cur_mask     = mask_mem[idx_q[AW-1:0]];
  assign entry_hit    = ((s2 ^ cur_data) & cur_mask) == '0;
  assign same_as_last = ((s2 ^ last_q) & cur_mask) == '0;
  assign len_clamped  = (seq_len > LW'(DEPTH)) ? LW'(DEPTH) : seq_len;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    len_d        = len_q;
    timer_d      = timer_q;
    strict_d     = strict_q;
    last_d       = last_q;
    pass_d       = pass;
    fail_d       = fail;
    timed_out_d  = timed_out;
    fail_value_d = fail_value;
    case (state_q)
      ST_RUN: begin
        timer_d = timer_q + TW'(1);
        if (eval_now) begin
          if (entry_hit) begin
            idx_d  = idx_q + LW'(1);
            last_d = s2;
            if (idx_q + LW'(1) == len_q) begin
              state_d = ST_PASS;
              pass_d  = 1'b1;
            end
          end else if (strict_q && (idx_q != '0) && !same_as_last) begin
            state_d      = ST_FAIL;
            fail_d       = 1'b1;
            fail_value_d = s2;
          end
        end
        // Timeout only applies if nothing above already ended the run, so a
        // completing match in the final cycle still reports pass.
        if (TO_EN && (timer_q == T_LAST) && (state_d == ST_RUN)) begin
          state_d     = ST_FAIL;
          fail_d      = 1'b1;
          timed_out_d = 1'b1;
        end
      end
      ST_IDLE, ST_PASS, ST_FAIL: begin
        if (start) begin
          idx_d        = '0;
          timer_d      = '0;
          len_d        = len_clamped;
          strict_d     = strict;
          last_d       = '0;
          pass_d       = 1'b0;
          fail_d       = 1'b0;
          timed_out_d  = 1'b0;
          fail_value_d = '0;
          if (len_clamped == '0) begin
            state_d = ST_PASS;
            pass_d  = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      len_q      <= '0;
      timer_q    <= '0;
      strict_q   <= 1'b0;
      last_q     <= '0;
      pass       <= 1'b0;
      fail       <= 1'b0;
      timed_out  <= 1'b0;
      fail_value <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      len_q      <= len_d;
      timer_q    <= timer_d;
      strict_q   <= strict_d;
      last_q     <= last_d;
      pass       <= pass_d;
      fail       <= fail_d;
      timed_out  <= timed_out_d;
      fail_value <= fail_value_d;
    end
  end

  assign busy      = (state_q == ST_RUN);
  assign match_idx = idx_q;

endmodule

// File: tb/tb_mprj_io_seq_checker.sv
// Bench for mprj_io_seq_checker: single-entry vector table plus hand-built multi-cycle sequences.
module tb_mprj_io_seq_checker;

  localparam int W  = 8;
  localparam int D  = 16;
  localparam int SC = 2;
  localparam int TO = 300;

  logic         clock = 1'b0;
  logic         resetb;
  logic [W-1:0] io_in;
  logic         exp_we;
  logic [3:0]   exp_addr;
  logic [W-1:0] exp_data;
  logic [W-1:0] exp_mask;
  logic [4:0]   seq_len;
  logic         strict;
  logic         start;
  logic         busy, pass, fail, timed_out;
  logic [4:0]   match_idx;
  logic [W-1:0] fail_value;

  mprj_io_seq_checker #(
    .WIDTH(W), .DEPTH(D), .STABLE_CYCLES(SC), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock(clock), .resetb(resetb), .io_in(io_in), .exp_we(exp_we),
    .exp_addr(exp_addr), .exp_data(exp_data), .exp_mask(exp_mask),
    .seq_len(seq_len), .strict(strict), .start(start), .busy(busy),
    .pass(pass), .fail(fail), .timed_out(timed_out), .match_idx(match_idx),
    .fail_value(fail_value)
  );

  always #5 clock = ~clock;

  int edge_cnt = 0;
  always @(posedge clock) edge_cnt <= edge_cnt + 1;

  int n_cmp = 0;
  int n_bad = 0;
  int s_edge = 0;

  typedef struct {
    string        name;
    logic         busy, pass, fail, to;
    logic [4:0]   idx;
    logic [W-1:0] fv;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    string        name;
    logic [W-1:0] data, mask, drv;
    logic         strict_en, hit;
  } vec_t;
  vec_t vq[$];

  logic [W-1:0] seq_vals [12] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
                                  8'h07, 8'h08, 8'h09, 8'h0A, 8'hFF, 8'h00};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  task automatic push_exp(input string nm, input logic b, p, f, t,
                          input logic [4:0] i, input logic [W-1:0] fv);
    exp_t e;
    e.name = nm; e.busy = b; e.pass = p; e.fail = f; e.to = t; e.idx = i; e.fv = fv;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_empty: got no entry, required one");
    end else begin
      e = sb.pop_front();
      chk({e.name, ".busy"},       busy,       e.busy);
      chk({e.name, ".pass"},       pass,       e.pass);
      chk({e.name, ".fail"},       fail,       e.fail);
      chk({e.name, ".timed_out"},  timed_out,  e.to);
      chk({e.name, ".match_idx"},  match_idx,  e.idx);
      chk({e.name, ".fail_value"}, fail_value, e.fv);
    end
  endtask

  function automatic logic [W-1:0] filler();
    return W'($urandom_range(16, 240));
  endfunction

  task automatic do_reset();
    io_in  = '0;
    resetb = 1'b0;
    repeat (2) @(negedge clock);
    resetb = 1'b1;
    repeat (4) @(negedge clock);
  endtask

  task automatic prog(input int a, input logic [W-1:0] d, input logic [W-1:0] m);
    exp_addr = a[3:0]; exp_data = d; exp_mask = m; exp_we = 1'b1;
    @(negedge clock);
    exp_we = 1'b0;
  endtask

  task automatic prog_seq();
    for (int i = 0; i < 12; i++) prog(i, seq_vals[i], 8'hFF);
  endtask

  task automatic start_run(input logic [4:0] len, input logic s);
    seq_len = len; strict = s; start = 1'b1;
    @(negedge clock);
    start  = 1'b0;
    s_edge = edge_cnt;
  endtask

  task automatic drive(input logic [W-1:0] v, input int n);
    io_in = v;
    repeat (n) @(negedge clock);
  endtask

  task automatic run_full();
    for (int i = 0; i < 12; i++) begin
      drive(filler(), 4);
      drive(seq_vals[i], 4);
    end
  endtask

  task automatic wait_done(input int bound);
    int c;
    c = 0;
    while (busy === 1'b1 && c < bound) begin
      @(negedge clock);
      c++;
    end
  endtask

  task automatic add_vec(input string n, input logic [W-1:0] d, m, v, input logic s, h);
    vec_t x;
    x.name = n; x.data = d; x.mask = m; x.drv = v; x.strict_en = s; x.hit = h;
    vq.push_back(x);
  endtask

  initial begin
    add_vec("mask_hi",       8'hA0, 8'hF0, 8'hA7, 1'b0, 1'b1);
    add_vec("mask_hi_miss",  8'hA0, 8'hF0, 8'hB7, 1'b0, 1'b0);
    add_vec("full_hit",      8'h5A, 8'hFF, 8'h5A, 1'b0, 1'b1);
    add_vec("full_miss",     8'h5A, 8'hFF, 8'h5B, 1'b0, 1'b0);
    add_vec("mask_zero",     8'h00, 8'h00, 8'hC3, 1'b0, 1'b1);
    add_vec("strict_idx0",   8'h5A, 8'hFF, 8'h11, 1'b1, 1'b0);
    add_vec("mask_lo",       8'h05, 8'h0F, 8'hF5, 1'b1, 1'b1);
    add_vec("mask_bit_miss", 8'h80, 8'h80, 8'h7F, 1'b0, 1'b0);

    resetb = 1'b0; io_in = '0; exp_we = 1'b0; exp_addr = '0; exp_data = '0;
    exp_mask = '0; seq_len = '0; strict = 1'b0; start = 1'b0;
    repeat (3) @(negedge clock);
    push_exp("reset_in", 0, 0, 0, 0, 0, 0);
    pop_check();
    resetb = 1'b1;
    repeat (4) @(negedge clock);
    push_exp("reset_out", 0, 0, 0, 0, 0, 0);
    pop_check();

    // Nominal sequence with exact pass latency on the final value.
    prog_seq();
    drive(8'h55, 4);
    start_run(12, 1'b0);
    chk("nominal_busy_rise", busy, 1);
    push_exp("nominal", 0, 1, 0, 0, 12, 0);
    for (int i = 0; i < 11; i++) begin
      drive(seq_vals[i], 4);
      drive(filler(), 4);
    end
    io_in = 8'h00;
    repeat (SC + 2) @(negedge clock);
    chk("nominal_pre_pass", pass, 0);
    chk("nominal_pre_busy", busy, 1);
    chk("nominal_pre_idx", match_idx, 11);
    @(negedge clock);
    pop_check();

    // Glitch filter: 02 for only SC clocks is never seen, so the run times out.
    start_run(12, 1'b0);
    push_exp("glitch", 0, 0, 1, 1, 1, 0);
    drive(8'h01, 4);
    drive(filler(), 4);
    drive(8'h02, SC);
    drive(8'h03, 4);
    drive(8'h04, 4);
    wait_done(TO + 20);
    chk("glitch_timeout_edge", edge_cnt - s_edge, TO);
    pop_check();

    // Strict mismatch after one match; the idx=0 non-match 07 is tolerated.
    prog(0, 8'h01, 8'hFF); prog(1, 8'h02, 8'hFF); prog(2, 8'h03, 8'hFF);
    start_run(3, 1'b1);
    push_exp("strict_fail", 0, 0, 1, 0, 1, 8'h05);
    drive(8'h07, 4);
    drive(8'h01, 4);
    drive(8'h05, 4);
    wait_done(20);
    pop_check();

    // Strict: return to the last matched value after a glitch is tolerated.
    start_run(3, 1'b1);
    push_exp("strict_repeat", 0, 1, 0, 0, 3, 0);
    drive(8'h01, 4);
    drive(8'h09, 1);
    drive(8'h01, 4);
    drive(8'h02, 4);
    drive(8'h03, 4);
    wait_done(20);
    pop_check();

    foreach (vq[k]) begin
      do_reset();
      prog(0, vq[k].data, vq[k].mask);
      start_run(1, vq[k].strict_en);
      if (vq[k].hit) push_exp(vq[k].name, 0, 1, 0, 0, 1, 0);
      else           push_exp(vq[k].name, 1, 0, 0, 0, 0, 0);
      drive(vq[k].drv, SC + 3);
      pop_check();
    end

    do_reset();
    start_run(0, 1'b0);
    push_exp("len_zero", 0, 1, 0, 0, 0, 0);
    pop_check();

    // seq_len beyond DEPTH clamps to DEPTH; values held the minimum SC+1 clocks.
    do_reset();
    for (int i = 0; i < D; i++) prog(i, W'(8'h20 + i), 8'hFF);
    start_run(5'(D + 5), 1'b0);
    push_exp("clamp", 0, 1, 0, 0, 5'(D), 0);
    for (int i = 0; i < D; i++) begin
      drive(W'(8'h20 + i), SC + 1);
      drive(W'(8'hC0 + i), SC + 1);
    end
    wait_done(20);
    pop_check();

    // Final match lands on the timeout edge: pass wins.
    do_reset();
    prog(0, 8'h3C, 8'hFF);
    start_run(1, 1'b0);
    while (edge_cnt < s_edge + TO - (SC + 3)) @(negedge clock);
    io_in = 8'h3C;
    push_exp("coincident", 0, 1, 0, 0, 1, 0);
    wait_done(TO);
    chk("coincident_edge", edge_cnt - s_edge, TO);
    pop_check();

    // One clock later the timeout fires first.
    do_reset();
    prog(0, 8'h3C, 8'hFF);
    start_run(1, 1'b0);
    while (edge_cnt < s_edge + TO - (SC + 2)) @(negedge clock);
    io_in = 8'h3C;
    push_exp("late_match", 0, 0, 1, 1, 0, 0);
    wait_done(TO);
    chk("late_match_edge", edge_cnt - s_edge, TO);
    pop_check();

    // Asynchronous reset mid-run at idx=3.
    do_reset();
    prog_seq();
    start_run(12, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(filler(), 4);
      drive(seq_vals[i], 4);
    end
    drive(filler(), 4);
    chk("pre_reset_idx", match_idx, 3);
    #2 resetb = 1'b0;
    #1;
    push_exp("async_reset", 0, 0, 0, 0, 0, 0);
    pop_check();
    @(negedge clock);
    resetb = 1'b1;
    repeat (6) @(negedge clock);
    // Cleared entry 0 has mask 0, so any fresh value matches.
    start_run(1, 1'b0);
    push_exp("cleared_entry", 0, 1, 0, 0, 1, 0);
    drive(8'h00, SC + 3);
    pop_check();

    prog_seq();
    start_run(12, 1'b0);
    push_exp("rerun1", 0, 1, 0, 0, 12, 0);
    run_full();
    wait_done(20);
    pop_check();

    start_run(12, 1'b0);
    push_exp("restart_clear", 1, 0, 0, 0, 0, 0);
    pop_check();
    push_exp("rerun2", 0, 1, 0, 0, 12, 0);
    run_full();
    wait_done(20);
    pop_check();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule
